bus_out_arbiter: RTL
====================

# bus_out_arbiter

Per-PE arbiter that shares the 2×`DATA_SIZE` output bus between the two instruction slots. Each slot requests bus lanes (HI half, LO half, both) plus an optional single extra bit. Non-overlapping requests are granted together; overlapping requests are resolved by round-robin priority. Granted fields are registered and drive `busOutMux` for exactly one cycle, so the mux never sees two drivers on the same bit.

## Interface
- `PRIO_INIT`, default 0: slot holding priority after reset.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  slot request valid.
- `instOut0` / `instOut1`  in  `DATA_SIZE*2`  slot data.
- `validPart0` / `validPart1`  in  2  lanes requested.
- `extraBitToSet0` / `extraBitToSet1`  in  `LG_DATA_SIZE+1`  extra-bit index, 0..15.
- `extraBitValue0` / `extraBitValue1`  in  2  [1]=extra bit requested, [0]=value.
- `gnt0` / `gnt1`  out  1  combinational acceptance; transfer when `reqN & gntN` at the edge.
- `muxInstOut0/1`, `muxValidPart0/1`, `muxExtraBitToSet0/1`, `muxExtraBitValue0/1`  out  registered copies feeding `busOutMux`.
- `prio`  out  1  current priority holder.
- `conflictCount`  out  16  saturating conflict counter. Tied to 0 when `BUS_ARB_STATS_EN` is undefined.

## Operation
- Lane encodings (package): `VALID_PART_NONE`=2'b00, `VALID_PART_LO`=2'b01, `VALID_PART_HI`=2'b10, `VALID_PART_ALL`=2'b11.
- Lane mask: bit0=LO, bit1=HI, equal to `validPart`.
- Footprint of slot N: 16-bit mask built from its lane mask, OR'd with the one-hot of `extraBitToSetN` when `extraBitValueN[1]`.
- Footprint of a non-requesting slot is 0.
- Request with footprint 0 (NONE, no extra bit) is legal: granted, drives nothing.
- Conflict: `req0 & req1 & |(fp0 & fp1)`.
  - No conflict: `gnt0=req0`, `gnt1=req1`.
  - Conflict: only the `prio` slot is granted.
- Priority update at each edge:
  - Conflict: `prio` moves to the losing slot.
  - No conflict: `prio` unchanged.
  - This guarantees the loser is granted within one more cycle.
- Requester rule: hold `req` and all fields stable until granted. Changes while waiting are undefined.
- Register stage for a granted slot: captures its fields.
- Register stage for a non-granted slot:
  - `muxValidPartN` = NONE.
  - `muxExtraBitValueN[1]` = 0.
  - `muxInstOutN` / `muxExtraBitToSetN` hold their previous values.
- No lane reservation across cycles: each granted drive lasts exactly one cycle.

## Timing
- `gnt` is combinational from the same-cycle `req` and fields, with no path from `mux*` outputs.
- Latency: request accepted at edge t drives the bus during cycle t+1 only.
- Throughput: each slot can complete one transfer per cycle when its footprint does not conflict.
- Worst-case wait: 1 cycle for a slot that lost a conflict.
- Reset values:
  - `mux*` all zero, i.e. `muxValidPart` NONE, extra-bit invalid.
  - `prio=PRIO_INIT`.
  - `conflictCount=0`.
- Reset asserted mid-operation:
  - Pending requests are dropped; `gnt` forced 0 while `reset` is high.
  - The bus is undriven the cycle after reset.
  - Requesters re-present their requests after reset deasserts.
- Simultaneous events:
  - Both request ALL: conflict.
  - HI vs LO: no conflict.
  - LO vs extra bit 12: no conflict.
  - LO vs extra bit 3: conflict.
  - Equal extra-bit indices: conflict.

## Configuration
- `BUS_ARB_STATS_EN` defined:
  - `conflictCount` increments on every conflict cycle.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: the counter logic is absent and `conflictCount`=0. Arbitration is identical in both builds.

## Structure
- Shared package / defines header holds:
  - `DATA_SIZE`, `LG_DATA_SIZE`.
  - The `VALID_PART_*` encodings.
  - A footprint function: validPart, index, enable → 16-bit mask.
- One sub-module `bus_footprint`, instantiated twice: combinational footprint builder.
- Arbiter logic, `prio` register and output registers stay in the top level.

## Test plan
- Reset with PRIO_INIT=0, then `req0` ALL `instOut0`=16'hA55A alone → `gnt0`=1. Next cycle `muxValidPart0`=ALL, `muxInstOut0`=16'hA55A, slot 1 NONE.
- `req0` HI 16'h1200 plus `req1` LO 16'h0034 → both granted. Next cycle the mux shows 16'h1234.
- Both request ALL for 4 cycles, `prio`=0 initially → grants alternate 0,1,0,1; `prio` toggles each cycle; `conflictCount`=4 (stats build).
- `req0` LO plus `req1` extra bit index 3 value 1 → conflict, only `prio` slot granted. Repeat with index 12 → both granted, bit 12 driven 1.
- `req1` waiting after a lost conflict, then `reset` pulsed → `gnt1`=0 during reset. After reset all `mux*` are NONE/invalid and `prio`=PRIO_INIT.
- Stats build with counter preloaded near 16'hFFFF via a long conflict run → holds at 16'hFFFF. Non-stats build reads 0 throughout.

Source files
------------

// File: rtl/bus_out_arbiter_pkg.sv
// rtl/bus_out_arbiter_pkg.sv - shared widths, lane encodings and footprint helper
package bus_out_arbiter_pkg;

  localparam int DATA_SIZE    = 8;
  localparam int LG_DATA_SIZE = 3;
  localparam int BUS_W        = 2 * DATA_SIZE;

  localparam logic [1:0] VALID_PART_NONE = 2'b00;
  localparam logic [1:0] VALID_PART_LO   = 2'b01;
  localparam logic [1:0] VALID_PART_HI   = 2'b10;
  localparam logic [1:0] VALID_PART_ALL  = 2'b11;

  // Bits of the output bus a request would drive: its lanes plus the optional extra bit.
  function automatic logic [BUS_W-1:0] footprint(input logic [1:0] validPart,
                                                 input logic [LG_DATA_SIZE:0] index,
                                                 input logic enable);
    logic [BUS_W-1:0] mask;
    mask = {{DATA_SIZE{validPart[1]}}, {DATA_SIZE{validPart[0]}}};
    if (enable) mask[index] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/bus_out_arbiter_if.sv
// rtl/bus_out_arbiter_if.sv - slot request / mux output bundle of the bus arbiter
interface bus_out_arbiter_if;
  import bus_out_arbiter_pkg::*;

  logic                    req0, req1;
  logic [BUS_W-1:0]        instOut0, instOut1;
  logic [1:0]              validPart0, validPart1;
  logic [LG_DATA_SIZE:0]   extraBitToSet0, extraBitToSet1;
  logic [1:0]              extraBitValue0, extraBitValue1;
  logic                    gnt0, gnt1;
  logic [BUS_W-1:0]        muxInstOut0, muxInstOut1;
  logic [1:0]              muxValidPart0, muxValidPart1;
  logic [LG_DATA_SIZE:0]   muxExtraBitToSet0, muxExtraBitToSet1;
  logic [1:0]              muxExtraBitValue0, muxExtraBitValue1;
  logic                    prio;
  logic [15:0]             conflictCount;

  modport master (
    output req0, req1, instOut0, instOut1, validPart0, validPart1,
           extraBitToSet0, extraBitToSet1, extraBitValue0, extraBitValue1,
    input  gnt0, gnt1, muxInstOut0, muxInstOut1, muxValidPart0, muxValidPart1,
           muxExtraBitToSet0, muxExtraBitToSet1, muxExtraBitValue0, muxExtraBitValue1,
           prio, conflictCount
  );

  modport slave (
    input  req0, req1, instOut0, instOut1, validPart0, validPart1,
           extraBitToSet0, extraBitToSet1, extraBitValue0, extraBitValue1,
    output gnt0, gnt1, muxInstOut0, muxInstOut1, muxValidPart0, muxValidPart1,
           muxExtraBitToSet0, muxExtraBitToSet1, muxExtraBitValue0, muxExtraBitValue1,
           prio, conflictCount
  );

endinterface

// File: rtl/bus_footprint.sv
// rtl/bus_footprint.sv - combinational footprint of one slot; zero when not requesting
module bus_footprint
  import bus_out_arbiter_pkg::*;
(
  input  logic                  req,
  input  logic [1:0]            validPart,
  input  logic [LG_DATA_SIZE:0] extraBitToSet,
  input  logic                  extraBitEn,
  output logic [BUS_W-1:0]      fp
);

  assign fp = req ? footprint(validPart, extraBitToSet, extraBitEn) : '0;

endmodule

// File: rtl/bus_out_arbiter.sv
// rtl/bus_out_arbiter.sv - two-slot round-robin arbiter for the shared PE output bus
// Optional saturating conflict counter enabled by BUS_ARB_STATS_EN.
module bus_out_arbiter
  import bus_out_arbiter_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
)(
  input logic         clk,
  input logic         reset,
  bus_out_arbiter_if.slave bus
);

  logic [BUS_W-1:0] fp0, fp1;
  logic             conflict;
  logic             gnt0, gnt1;
  logic             prio;

  bus_footprint fpSlot0 (
    .req(bus.req0), .validPart(bus.validPart0), .extraBitToSet(bus.extraBitToSet0),
    .extraBitEn(bus.extraBitValue0[1]), .fp(fp0)
  );

  bus_footprint fpSlot1 (
    .req(bus.req1), .validPart(bus.validPart1), .extraBitToSet(bus.extraBitToSet1),
    .extraBitEn(bus.extraBitValue1[1]), .fp(fp1)
  );

  // Grants depend only on this cycle's requests and prio, never on the mux registers.
  always_comb begin
    conflict = bus.req0 & bus.req1 & (|(fp0 & fp1));
    gnt0     = ~reset & bus.req0 & (~conflict | ~prio);
    gnt1     = ~reset & bus.req1 & (~conflict | prio);
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign bus.prio = prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PRIO_INIT;
    end else if (conflict) begin
      prio <= ~prio;
    end
  end

  // Non-granted slots drop their lanes and extra bit so no stale drive reaches the mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.muxInstOut0       <= '0;
      bus.muxValidPart0     <= VALID_PART_NONE;
      bus.muxExtraBitToSet0 <= '0;
      bus.muxExtraBitValue0 <= '0;
    end else if (gnt0) begin
      bus.muxInstOut0       <= bus.instOut0;
      bus.muxValidPart0     <= bus.validPart0;
      bus.muxExtraBitToSet0 <= bus.extraBitToSet0;
      bus.muxExtraBitValue0 <= bus.extraBitValue0;
    end else begin
      bus.muxValidPart0     <= VALID_PART_NONE;
      bus.muxExtraBitValue0 <= {1'b0, bus.muxExtraBitValue0[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.muxInstOut1       <= '0;
      bus.muxValidPart1     <= VALID_PART_NONE;
      bus.muxExtraBitToSet1 <= '0;
      bus.muxExtraBitValue1 <= '0;
    end else if (gnt1) begin
      bus.muxInstOut1       <= bus.instOut1;
      bus.muxValidPart1     <= bus.validPart1;
      bus.muxExtraBitToSet1 <= bus.extraBitToSet1;
      bus.muxExtraBitValue1 <= bus.extraBitValue1;
    end else begin
      bus.muxValidPart1     <= VALID_PART_NONE;
      bus.muxExtraBitValue1 <= {1'b0, bus.muxExtraBitValue1[0]};
    end
  end

`ifdef BUS_ARB_STATS_EN
  logic [15:0] conflictCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      conflictCount <= '0;
    end else if (conflict && conflictCount != 16'hFFFF) begin
      conflictCount <= conflictCount + 16'd1;
    end
  end

  assign bus.conflictCount = conflictCount;
`else
  assign bus.conflictCount = '0;
`endif

endmodule
